seq_divider: RTL and testbench

//   Multi-cycle restoring divider: inverse of the MAC adder/accumulator datapath.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 149 ++++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC slice post-processing blocks: divider FSM
// encoding, default datapath width and counter sizing helper.
package mac_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ZERO,
    DONE,
    FIXUP
  } div_state_t;

  // Bits needed to count WIDTH-1 down to 0; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep or restore the partial remainder.
module div_step
  import mac_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  // A non-negative difference is always < divisor, so its upper bit is zero.
  always_comb begin
    shifted = {rem_in, dvd_msb};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, start/busy/done.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (one extra fix-up cycle).
module seq_divider
  import mac_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r, dvd_r, dsr_r, dividend_r;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;
  logic             accept;
  logic             last_step;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q_r, neg_r_r;

  function automatic logic [WIDTH-1:0] neg_if(input logic signed [WIDTH-1:0] v,
                                              input logic neg);
    return neg ? -v : v;
  endfunction

  // MIN maps to itself, which read unsigned is exactly its magnitude.
  assign dividend_mag = neg_if($signed(dividend), dividend[WIDTH-1]);
  assign divisor_mag  = neg_if($signed(divisor), divisor[WIDTH-1]);
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  assign last_step = (cnt == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .dvd_msb (dvd_r[WIDTH-1]),
    .divisor (dsr_r),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CW'(WIDTH - 1);
      else if (state == CALC && !last_step)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) begin
`ifdef SEQ_DIV_SIGNED_EN
          state_nxt = FIXUP;
`else
          state_nxt = DONE;
`endif
        end
      end
      ZERO: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      FIXUP: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: dvd_r shifts dividend bits out and quotient bits in.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_r      <= '0;
      dvd_r      <= dividend_mag;
      dsr_r      <= divisor_mag;
      dividend_r <= dividend;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_r    <= dividend[WIDTH-1];
`endif
    end else if (state == CALC) begin
      rem_r <= rem_step;
      dvd_r <= {dvd_r[WIDTH-2:0], q_bit};
    end
  end

  // Results only change on the edge into DONE, so they hold across operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == ZERO) begin
      quotient    <= '1;
      remainder   <= dividend_r;
      div_by_zero <= 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
    end else if (state == FIXUP) begin
      quotient    <= neg_if($signed(dvd_r), neg_q_r);
      remainder   <= neg_if($signed(rem_r), neg_r_r);
      div_by_zero <= 1'b0;
`else
    end else if (state == CALC && last_step) begin
      quotient    <= {dvd_r[WIDTH-2:0], q_bit};
      remainder   <= rem_step;
      div_by_zero <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_seq_divider;

  localparam int W = 8;
`ifdef SEQ_DIV_SIGNED_EN
  localparam int FIX = 1;
`else
  localparam int FIX = 0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           t0;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;
  int   n_acc = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
`ifdef SEQ_DIV_SIGNED_EN
    int da, ds;
`endif
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      da = $signed(a);
      ds = $signed(b);
      q  = W'(da / ds);
      r  = W'(da % ds);
`else
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  // Drive start for one cycle; the cycle index while start is held is t.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
    e.t0  = cyc;
    e.lat = (b == '0) ? 2 : W + 1 + FIX;
    sb.push_back(e);
    n_acc++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    issue(a, b, q, r, z);
    wait_done(40);
  endtask

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      logic [W-1:0] inv;
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done with no accepted start at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("latency", cyc - e.t0, e.lat);
        if (e.b != '0) begin
          inv = W'(quotient * e.b + remainder);
          chk("invariant", inv, e.a);
`ifndef SEQ_DIV_SIGNED_EN
          chk("rem_lt_div", remainder < e.b, 1);
`endif
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, q, r;
    logic         z;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

`ifdef SEQ_DIV_SIGNED_EN
    op(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0);
    op(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0);
    op(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0);
    op(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1);
    op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);
`else
    op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    op(8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
    op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("hold_quotient", quotient, 3);
    chk("hold_remainder", remainder, 1);
    chk("hold_dbz", div_by_zero, 0);

    // Starts while busy and on the done cycle must all be dropped.
    issue(8'd100, 8'd10, 8'd10, 8'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      start = 1'b1; dividend = 8'd1; divisor = 8'd1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(40);
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("one_done_per_start", n_done, n_acc);
    chk("hold_after_ignored", quotient, 10);
    chk("busy_after_ignored", busy, 0);

    // Reset in the middle of a calculation aborts it without a done pulse.
    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    sb.delete();
    n_acc--;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_no_done", n_done, n_acc);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      if (i % 50 == 0) b = '0;
      model(a, b, q, r, z);
      op(a, b, q, r, z);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("total_done", n_done, n_acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
